// File: rtl/bus_timer_periph_pkg.sv
// Shared constants for the bus timer peripheral: register map and CTRL layout.
package bus_timer_periph_pkg;

    // Word offsets inside the 4-word register window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_RELOAD = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // CTRL bit positions
    localparam int EN        = 0;
    localparam int AUTO      = 1;
    localparam int IE        = 2;
    localparam int PRESC_LSB = 8;

    // Bits of CTRL that are actually stored; [7:3] always read back as 0
    localparam logic [15:0] CTRL_WR_MASK = 16'hFF07;

    function automatic logic [15:0] ctrl_filter(input logic [15:0] value);
        return value & CTRL_WR_MASK;
    endfunction

endpackage

// File: rtl/bus_timer_periph_if.sv
// CPU-side control signals of the timer peripheral (address, direction, interrupts).
// The bidirectional data bus stays a plain inout port on the peripheral.
interface bus_timer_periph_if;
    logic        oe;
    logic [15:0] Direcciones;
    logic [7:0]  intr_out;

    modport master (output oe, output Direcciones, input intr_out);
    modport slave  (input oe, input Direcciones, output intr_out);
endinterface

// File: rtl/bus_timer_periph_timer_prescaler.sv
// Prescaler: emits a one-clock tick every i_presc+1 clocks while enabled.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [7:0] i_presc,
    input  logic       i_clear,
    output logic       o_tick
);
    logic [7:0] r_cnt;

    // Tick fires when the count reaches the programmed divisor
    assign o_tick = i_en & (r_cnt == i_presc);

    // Divider count: held at 0 while disabled or when CTRL is rewritten
    always_ff @(posedge clk) begin
        if (reset || !i_en || i_clear) begin
            r_cnt <= 8'd0;
        end else if (o_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/bus_timer_periph.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and interrupt.
module bus_timer_periph #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          INTR_BIT  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_timer_periph_if.slave     bus,
    inout  wire  [15:0]           Datos
);
    import bus_timer_periph_pkg::*;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd_en;
    logic        w_ctrl_wr;
    logic        w_reload_wr;
    logic        w_count_wr;
    logic        w_status_wr;
    logic        w_tick_raw;
    logic        w_tick;
    logic        w_expire;
    logic [15:0] w_rd_data;
    logic [7:0]  w_intr_next;

    logic [15:0] r_ctrl;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic        r_exp;
    logic [7:0]  r_intr;

    assign w_hit       = (bus.Direcciones[15:2] == BASE_ADDR[15:2]);
    assign w_off       = bus.Direcciones[1:0];
    assign w_wr        = w_hit & bus.oe;
    assign w_rd_en     = w_hit & ~bus.oe;
    assign w_ctrl_wr   = w_wr & (w_off == OFF_CTRL);
    assign w_reload_wr = w_wr & (w_off == OFF_RELOAD);
    assign w_count_wr  = w_wr & (w_off == OFF_COUNT);
    assign w_status_wr = w_wr & (w_off == OFF_STATUS);

    timer_prescaler u_presc (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_ctrl[EN]),
        .i_presc (r_ctrl[15:PRESC_LSB]),
        .i_clear (w_ctrl_wr),
        .o_tick  (w_tick_raw)
    );

    // A CTRL write that turns the timer off swallows a tick landing on the same edge
    assign w_tick   = w_tick_raw & ~(w_ctrl_wr & ~Datos[EN]);
    // Expiry only when the tick actually decrements (a COUNT write overrides it)
    assign w_expire = w_tick & ~w_count_wr & (r_count == 16'd1);

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= 16'd0;
            r_reload <= 16'd0;
        end else begin
            if (w_ctrl_wr)   r_ctrl   <= ctrl_filter(Datos);
            if (w_reload_wr) r_reload <= Datos;
        end
    end

    // Down-counter: bus write has priority over the tick; stalls at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_count_wr) begin
            r_count <= Datos;
        end else if (w_tick) begin
            if (r_count == 16'd1) begin
                r_count <= r_ctrl[AUTO] ? r_reload : 16'd0;
            end else if (r_count != 16'd0) begin
                r_count <= r_count - 16'd1;
            end
        end
    end

    // Expiry flag: a new expiry beats a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_status_wr && Datos[0]) begin
            r_exp <= 1'b0;
        end
    end

    // Only the configured interrupt line carries EXP & IE; the rest stay low
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_intr
            assign w_intr_next[gi] = (gi == INTR_BIT) ? (r_exp & r_ctrl[IE]) : 1'b0;
        end
    endgenerate

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_intr <= 8'h00;
        end else begin
            r_intr <= w_intr_next;
        end
    end

    assign bus.intr_out = r_intr;

    // Read-data mux for the addressed register
    always_comb begin
        w_rd_data = 16'd0;
        case (w_off)
            OFF_CTRL:   w_rd_data = r_ctrl;
            OFF_RELOAD: w_rd_data = r_reload;
            OFF_COUNT:  w_rd_data = r_count;
            OFF_STATUS: w_rd_data = {15'd0, r_exp};
            default:    w_rd_data = 16'd0;
        endcase
    end

    assign Datos = w_rd_en ? w_rd_data : 16'hzzzz;

endmodule

// File: doc/bus_timer_periph.md
Name: bus_timer_periph

Overview:
- Memory-mapped timer peripheral that sits on the CPU data/address bus as a responder.
- Decodes `Direcciones`, accepts writes when the CPU drives `Datos` (`oe`=1), and drives `Datos` on reads (`oe`=0).
- Provides a prescaled 16-bit down-counter with optional auto-reload.
- Raises one bit of an 8-bit interrupt vector that feeds the CPU's `intr_in` interrupt lines.

Parameters:
- BASE_ADDR, 16'hFF00, base address of the 4-word register window; low 2 bits must be 0.
- INTR_BIT, 0, index (0..7) of the `intr_out` line this block drives.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- oe  input  1  CPU transceiver enable; 1 = CPU drives `Datos` (write), 0 = CPU reads
- Direcciones  input  16  bus address from CPU
- Datos  inout  16  bidirectional data bus; driven by this block only on a read hit, else high-Z
- intr_out  output  8  interrupt request lines; only bit INTR_BIT is ever nonzero

Behaviour:
- Decode: hit = (Direcciones[15:2] == BASE_ADDR[15:2]); offset = Direcciones[1:0].
- Registers:
  - 0 CTRL (R/W): [0] EN, [1] AUTO, [2] IE, [15:8] PRESC; [7:3] read as 0.
  - 1 RELOAD (R/W).
  - 2 COUNT (R; a write loads the counter).
  - 3 STATUS: [0] EXP; write 1 to bit 0 clears it; other bits read as 0.
- Write: on a rising edge with hit & oe=1, Datos is captured into the addressed register. A write is applied every cycle the condition holds; no handshake, zero wait states.
- Read: combinational; hit & oe=0 drives the addressed register value onto Datos in the same cycle; otherwise Datos = 16'hZZZZ.
- Reset: CTRL=0, RELOAD=0, COUNT=0, EXP=0, prescaler=0, intr_out=8'h00, Datos released (high-Z).
- Prescaler:
  - 8-bit counter; when EN=1, tick asserts for one clock every PRESC+1 clocks (PRESC=0 gives a tick every clock).
  - Prescaler clears to 0 when EN=0 and on any CTRL write.
  - First tick after enable arrives PRESC+1 clocks after the enabling write edge.
- Counter, on tick:
  - COUNT==0: no change, no flag.
  - COUNT==1: COUNT <= AUTO ? RELOAD : 0, and EXP <= 1.
  - Otherwise: COUNT <= COUNT-1.
  - Resulting period with AUTO is RELOAD ticks. RELOAD=0 with AUTO stops the counter at 0 after one expiry.
- Interrupt: intr_out[INTR_BIT] = EXP & IE (level, registered), asserted the clock after EXP sets. Remains high until software clears EXP or IE.
- Simultaneous events:
  - COUNT write in the same cycle as a tick: write wins, no decrement, no flag.
  - STATUS clear in the same cycle as an expiry: set wins, EXP stays 1.
  - CTRL write setting EN=0 in a tick cycle: the tick is discarded.
- Reset mid-count or mid-bus-cycle: all state returns to reset values at that edge. No partial write survives.

Decomposition:
- Shared package holds:
  - register offset constants: OFF_CTRL=0, OFF_RELOAD=1, OFF_COUNT=2, OFF_STATUS=3;
  - CTRL bit-position constants: EN=0, AUTO=1, IE=2, PRESC_LSB=8.
- One natural sub-module: `timer_prescaler` (EN, PRESC, clear → tick).
- Bus decode, register file, counter and tri-state driver stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles → all reads return 0, intr_out=8'h00, Datos high-Z when address misses.
- One-shot: write RELOAD=5 and COUNT=3, then CTRL=16'h0005 (EN, IE, PRESC=0) → COUNT reads 2,1,0 on successive clocks; EXP=1 on the third tick; intr_out=8'h01 one clock later; COUNT stays 0.
- Auto-reload with prescale: COUNT=2, RELOAD=4, CTRL=16'h0207 (PRESC=2) → ticks every 3 clocks; first expiry after 6 clocks, then every 12 clocks; COUNT sequence 2,1,4,3,2,1,4…
- Clear race: arrange expiry on the same edge as a write of 1 to STATUS → EXP remains 1 and the interrupt stays high; clear one cycle later → intr_out returns to 8'h00 the following clock.
- Bus isolation: reads and writes at BASE_ADDR+4 and 16'h00FF → no register changes, Datos never driven. A read at BASE+2 with oe=1 → block does not drive Datos.
- Reset mid-count: COUNT=100, EN=1; assert reset after 10 ticks → COUNT=0, CTRL=0 on the next read; no interrupt.
